// File: rtl/gmii_frame_stats_pkg.sv
// ---------------------------------------------------------------------------
// gmii_frame_stats_pkg
// Shared types and constants for the GMII receive statistics block:
// the receive FSM state enum, the histogram bin count and boundaries,
// the preamble/SFD framing constants, the width of the per-frame length
// accumulator, and the helper that maps a frame length onto a bin.
// ---------------------------------------------------------------------------
package gmii_frame_stats_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } state_t;

   localparam int NUM_BINS = 8;
   localparam int LEN_W    = 16;

   // Seven 0x55 octets followed by the SFD make up the 8-octet preamble.
   localparam logic [3:0] PRE_OCTETS = 4'd8;
   localparam logic [3:0] SFD_INDEX  = 4'd7;
   localparam logic [7:0] SFD_OCTET  = 8'hD5;

   // Upper edges of the fixed histogram bins.
   localparam logic [LEN_W-1:0] MIN_FRAME_LEN = 16'd64;
   localparam logic [LEN_W-1:0] BIN2_MAX      = 16'd127;
   localparam logic [LEN_W-1:0] BIN3_MAX      = 16'd255;
   localparam logic [LEN_W-1:0] BIN4_MAX      = 16'd511;
   localparam logic [LEN_W-1:0] BIN5_MAX      = 16'd1023;

   // Bin 6 runs from 1024 up to the configured maximum frame size, and
   // everything longer lands in bin 7.
   function automatic logic [2:0] lenToBin(input logic [LEN_W-1:0] len,
                                           input logic [LEN_W-1:0] maxFrame);
      logic [2:0] bin;
      if (len < MIN_FRAME_LEN)       bin = 3'd0;
      else if (len == MIN_FRAME_LEN) bin = 3'd1;
      else if (len <= BIN2_MAX)      bin = 3'd2;
      else if (len <= BIN3_MAX)      bin = 3'd3;
      else if (len <= BIN4_MAX)      bin = 3'd4;
      else if (len <= BIN5_MAX)      bin = 3'd5;
      else if (len <= maxFrame)      bin = 3'd6;
      else                           bin = 3'd7;
      return bin;
   endfunction

endpackage

// File: rtl/gmii_sat_counter.sv
// ---------------------------------------------------------------------------
// gmii_sat_counter
// One saturating statistics counter.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : amount to add this cycle
//   clr      : restart the count from zero at the coming edge
//   value    : current count plus this cycle's increment, saturated at
//              all-ones; this is exactly what the count becomes at the
//              coming edge unless clr is high, so a snapshot taken now
//              captures everything committed at that edge
// ---------------------------------------------------------------------------
module gmii_sat_counter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] inc,
   input  logic         clr,
   output logic [W-1:0] value
);

   logic [W-1:0] r_count;
   logic [W:0]   w_sum;

   // The extra sum bit is the carry; a carry means the count would wrap,
   // so it pins at all-ones instead.
   assign w_sum = {1'b0, r_count} + {1'b0, inc};
   assign value = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

   // A clear drops this cycle's increment from the live count; the caller
   // captures it through value in the same cycle so nothing is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      r_count <= '0;
      else if (clr) r_count <= '0;
      else          r_count <= value;
   end

endmodule

// File: rtl/gmii_frame_stats.sv
// ---------------------------------------------------------------------------
// gmii_frame_stats
// GMII receive statistics: counts good frames, their data octets, idle lane
// octets and errored frames, and keeps a frame length histogram, all behind
// a snapshot register set.
//   clk, rst        : clock and asynchronous active-high reset
//   gmii_d          : receive octets, lane 0 earliest
//   gmii_en         : per-lane enable, contiguous from lane 0
//   gmii_er         : per-lane receive error
//   snap            : single-cycle snapshot request
//   clear_on_snap   : with snap, restart the live counters
//   snap_valid      : pulses the cycle after snap
//   pkts, octets, octets_idle, err_frames : snapshot counters
//   hist            : snapshot length histogram, bin 0 in the LSBs
// ---------------------------------------------------------------------------
module gmii_frame_stats
   import gmii_frame_stats_pkg::*;
#(
   parameter int LANES     = 1,
   parameter int CNT_W     = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [8*LANES-1:0]        gmii_d,
   input  logic [LANES-1:0]          gmii_en,
   input  logic [LANES-1:0]          gmii_er,
   input  logic                      snap,
   input  logic                      clear_on_snap,
   output logic                      snap_valid,
   output logic [CNT_W-1:0]          pkts,
   output logic [CNT_W-1:0]          octets,
   output logic [CNT_W-1:0]          octets_idle,
   output logic [CNT_W-1:0]          err_frames,
   output logic [NUM_BINS*CNT_W-1:0] hist
);

   localparam int NUM_CNT = 4 + NUM_BINS;

   state_t            r_state, w_nextState;
   logic [3:0]        r_preCnt, w_preCnt;
   logic [LEN_W-1:0]  r_len, w_len;
   logic              r_armed;
   logic              w_start, w_inFrame, w_bad, w_end, w_badEnd, w_goodEnd;
   logic [3:0]        w_idleOctets;
   logic [2:0]        w_bin;
   logic              w_clr;
   logic              r_snapValid;
   logic [CNT_W-1:0]  w_inc  [NUM_CNT];
   logic [CNT_W-1:0]  w_live [NUM_CNT];
   logic [CNT_W-1:0]  r_snap [NUM_CNT];

   // Walk the lanes in arrival order so a single cycle can hold the tail of
   // the preamble, the SFD and the first data octets. Preamble octets only
   // advance the preamble count; the rest grow the saturating length.
   // An error on any enabled lane, or a wrong SFD, marks the frame bad.
   always_comb begin
      w_start   = (r_state == IDLE) && r_armed && gmii_en[0];
      w_inFrame = (r_state != IDLE) || w_start;
      w_preCnt  = w_start ? 4'd0 : r_preCnt;
      w_len     = w_start ? '0 : r_len;
      w_bad     = (r_state == DROP);
      for (int i = 0; i < LANES; i++) begin
         if (w_inFrame && gmii_en[i]) begin
            if (gmii_er[i]) w_bad = 1'b1;
            if (w_preCnt < PRE_OCTETS) begin
               if ((w_preCnt == SFD_INDEX) && (gmii_d[8*i +: 8] != SFD_OCTET))
                  w_bad = 1'b1;
               w_preCnt = w_preCnt + 4'd1;
            end else if (w_len != {LEN_W{1'b1}}) begin
               w_len = w_len + 16'd1;
            end
         end
      end
      // Any mask short of all-ones closes the frame; an all-zero mask
      // closes it with nothing added from this cycle. A frame that never
      // got past its preamble is counted as errored.
      w_end     = w_inFrame && (gmii_en != {LANES{1'b1}});
      w_badEnd  = w_end && (w_bad || (w_preCnt < PRE_OCTETS));
      w_goodEnd = w_end && !w_badEnd;
   end

   // Next-state decode follows the lane walk: back to IDLE at frame end,
   // DROP once the frame is known bad, otherwise by preamble progress.
   always_comb begin
      w_nextState = r_state;
      if (!w_inFrame || w_end)      w_nextState = IDLE;
      else if (w_bad)               w_nextState = DROP;
      else if (w_preCnt < PRE_OCTETS) w_nextState = PREAMBLE;
      else                          w_nextState = DATA;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Per-frame accumulators restart whenever the FSM returns to IDLE.
   // After reset the receiver stays disarmed until lane 0 has been seen
   // idle, so the tail of a frame cut by reset is never mistaken for a
   // new frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_preCnt <= 4'd0;
         r_len    <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_preCnt <= (w_nextState == IDLE) ? 4'd0 : w_preCnt;
         r_len    <= (w_nextState == IDLE) ? '0 : w_len;
         r_armed  <= r_armed | ~gmii_en[0];
      end
   end

   // Idle octets are the lanes without enable, every cycle.
   always_comb begin
      w_idleOctets = 4'(LANES);
      for (int i = 0; i < LANES; i++) begin
         if (gmii_en[i]) w_idleOctets = w_idleOctets - 4'd1;
      end
   end

   assign w_bin  = lenToBin(w_len, LEN_W'(MAX_FRAME));
   assign w_clr  = snap & clear_on_snap;
   assign w_inc[0] = CNT_W'(w_goodEnd);
   assign w_inc[1] = w_goodEnd ? CNT_W'(w_len) : '0;
   assign w_inc[2] = CNT_W'(w_idleOctets);
   assign w_inc[3] = CNT_W'(w_badEnd);

   genvar g;
   for (g = 0; g < NUM_BINS; g++) begin : gHistInc
      assign w_inc[4+g] = CNT_W'(w_goodEnd && (w_bin == 3'(g)));
   end

   for (g = 0; g < NUM_CNT; g++) begin : gCnt
      gmii_sat_counter #(.W(CNT_W)) uCnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (w_inc[g]),
         .clr   (w_clr),
         .value (w_live[g])
      );
   end

   // Snapshot registers load the counters' post-edge values, so a frame
   // that ends in the snap cycle is included, and hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snapValid <= 1'b0;
         for (int k = 0; k < NUM_CNT; k++) r_snap[k] <= '0;
      end else begin
         r_snapValid <= snap;
         if (snap) begin
            for (int k = 0; k < NUM_CNT; k++) r_snap[k] <= w_live[k];
         end
      end
   end

   assign snap_valid  = r_snapValid;
   assign pkts        = r_snap[0];
   assign octets      = r_snap[1];
   assign octets_idle = r_snap[2];
   assign err_frames  = r_snap[3];

   for (g = 0; g < NUM_BINS; g++) begin : gHistOut
      assign hist[g*CNT_W +: CNT_W] = r_snap[4+g];
   end

endmodule

// File: tb/tb_gmii_frame_stats.sv
// ---------------------------------------------------------------------------
// tb_gmii_frame_stats
// Directed bench: a single-lane instance with 16-bit counters and a
// four-lane instance with 64-bit counters share one clock and reset.
// ---------------------------------------------------------------------------
module tb_gmii_frame_stats;

   logic         clk = 1'b0;
   logic         rst;

   logic [7:0]   aD;
   logic [0:0]   aEn, aEr;
   logic         aSnap, aClr, aSnapValid;
   logic [15:0]  aPkts, aOctets, aIdle, aErr;
   logic [127:0] aHist;

   logic [31:0]  bD;
   logic [3:0]   bEn, bEr;
   logic         bSnap, bClr, bSnapValid;
   logic [63:0]  bPkts, bOctets, bIdle, bErr;
   logic [511:0] bHist;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         dataLen;
      logic [7:0] sfd;
      int         errIdx;
      int         preLen;
      int         expPkts;
      int         expOctets;
      int         expErr;
      int         expBin;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   gmii_frame_stats #(.LANES(1), .CNT_W(16), .MAX_FRAME(1518)) dutA (
      .clk           (clk),
      .rst           (rst),
      .gmii_d        (aD),
      .gmii_en       (aEn),
      .gmii_er       (aEr),
      .snap          (aSnap),
      .clear_on_snap (aClr),
      .snap_valid    (aSnapValid),
      .pkts          (aPkts),
      .octets        (aOctets),
      .octets_idle   (aIdle),
      .err_frames    (aErr),
      .hist          (aHist)
   );

   gmii_frame_stats #(.LANES(4), .CNT_W(64), .MAX_FRAME(1518)) dutB (
      .clk           (clk),
      .rst           (rst),
      .gmii_d        (bD),
      .gmii_en       (bEn),
      .gmii_er       (bEr),
      .snap          (bSnap),
      .clear_on_snap (bClr),
      .snap_valid    (bSnapValid),
      .pkts          (bPkts),
      .octets        (bOctets),
      .octets_idle   (bIdle),
      .err_frames    (bErr),
      .hist          (bHist)
   );

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One cycle on the single-lane instance; returns #1 after the edge.
   task automatic applyStimulus(input logic [7:0] d, input logic en,
                                input logic er, input logic sn, input logic cl);
      aD = d; aEn = en; aEr = er; aSnap = sn; aClr = cl;
      @(posedge clk);
      #1;
   endtask

   // One cycle on the four-lane instance.
   task automatic applyWide(input logic [31:0] d, input logic [3:0] en,
                            input logic sn, input logic cl);
      bD = d; bEn = en; bEr = 4'b0; bSnap = sn; bClr = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic sendFrameA(input int dataLen, input logic [7:0] sfd,
                             input int errIdx, input int preLen, input int ipg,
                             input int snapAt, input logic cl);
      for (int p = 0; p < preLen; p++)
         applyStimulus((p == 7) ? sfd : 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < dataLen; i++)
         applyStimulus(8'(i), 1'b1, (i == errIdx), 1'b0, 1'b0);
      for (int g = 0; g < ipg; g++)
         applyStimulus(8'h00, 1'b0, 1'b0, (g == snapAt), cl && (g == snapAt));
      aSnap = 1'b0; aClr = 1'b0;
   endtask

   task automatic sendFrameB(input int dataLen, input int ipg, input int snapAt,
                             input logic cl);
      logic [7:0]  q[$];
      logic [31:0] d;
      logic [3:0]  en;
      for (int p = 0; p < 7; p++) q.push_back(8'h55);
      q.push_back(8'hD5);
      for (int i = 0; i < dataLen; i++) q.push_back(8'(i));
      for (int c = 0; c < q.size(); c += 4) begin
         d = '0; en = '0;
         for (int k = 0; k < 4; k++) begin
            if (c + k < q.size()) begin
               d[8*k +: 8] = q[c+k];
               en[k] = 1'b1;
            end
         end
         applyWide(d, en, 1'b0, 1'b0);
      end
      for (int g = 0; g < ipg; g++)
         applyWide(32'h0, 4'h0, (g == snapAt), cl && (g == snapAt));
      bSnap = 1'b0; bClr = 1'b0;
   endtask

   task automatic checkA(input string tag, input int p, input int o,
                         input int e, input int idle);
      checkOutput({tag, ".pkts"},   64'(aPkts),   64'(p));
      checkOutput({tag, ".octets"}, 64'(aOctets), 64'(o));
      checkOutput({tag, ".err"},    64'(aErr),    64'(e));
      if (idle >= 0) checkOutput({tag, ".idle"}, 64'(aIdle), 64'(idle));
   endtask

   initial begin
      vecs[0]  = '{64,   8'hD5, -1, 8, 1, 64,   0, 1};
      vecs[1]  = '{46,   8'hD5, -1, 8, 1, 46,   0, 0};
      vecs[2]  = '{65,   8'hD5, -1, 8, 1, 65,   0, 2};
      vecs[3]  = '{128,  8'hD5, -1, 8, 1, 128,  0, 3};
      vecs[4]  = '{256,  8'hD5, -1, 8, 1, 256,  0, 4};
      vecs[5]  = '{1023, 8'hD5, -1, 8, 1, 1023, 0, 5};
      vecs[6]  = '{1024, 8'hD5, -1, 8, 1, 1024, 0, 6};
      vecs[7]  = '{1518, 8'hD5, -1, 8, 1, 1518, 0, 6};
      vecs[8]  = '{1519, 8'hD5, -1, 8, 1, 1519, 0, 7};
      vecs[9]  = '{64,   8'hD5, 10, 8, 0, 0,    1, -1};
      vecs[10] = '{64,   8'hD4, -1, 8, 0, 0,    1, -1};
      vecs[11] = '{0,    8'hD5, -1, 5, 0, 0,    1, -1};
      vecs[12] = '{255,  8'hD5, -1, 8, 1, 255,  0, 3};

      rst = 1'b1;
      aD = '0; aEn = '0; aEr = '0; aSnap = 1'b0; aClr = 1'b0;
      bD = '0; bEn = '0; bEr = '0; bSnap = 1'b0; bClr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkA("reset", 0, 0, 0, 0);
      checkOutput("reset.snapValid", 64'(aSnapValid), 64'd0);
      checkOutput("reset.hist", 64'(aHist[63:0]), 64'd0);
      checkOutput("resetB.pkts", bPkts, 64'd0);
      rst = 1'b0;

      // Four lanes: ten 64-octet frames closed by an all-zero mask.
      repeat (3) applyWide(32'h0, 4'h0, 1'b0, 1'b0);
      applyWide(32'h0, 4'h0, 1'b1, 1'b1);
      for (int f = 0; f < 10; f++) sendFrameB(64, 3, (f == 9) ? 2 : -1, 1'b1);
      checkOutput("lane4_64.pkts",   bPkts,   64'd10);
      checkOutput("lane4_64.octets", bOctets, 64'd640);
      checkOutput("lane4_64.hist1",  bHist[64 +: 64],  64'd10);
      checkOutput("lane4_64.hist2",  bHist[128 +: 64], 64'd0);
      checkOutput("lane4_64.err",    bErr,    64'd0);
      checkOutput("lane4_64.idle",   bIdle,   64'd120);

      // Four lanes: 66-octet frames ending in a 4'b0011 mask.
      for (int f = 0; f < 10; f++) sendFrameB(66, 3, (f == 9) ? 2 : -1, 1'b1);
      checkOutput("lane4_66.pkts",   bPkts,   64'd10);
      checkOutput("lane4_66.octets", bOctets, 64'd660);
      checkOutput("lane4_66.hist2",  bHist[128 +: 64], 64'd10);
      checkOutput("lane4_66.hist1",  bHist[64 +: 64],  64'd0);
      checkOutput("lane4_66.idle",   bIdle,   64'd140);

      // Single lane: sync snapshot, then one frame per table entry.
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      aSnap = 1'b0; aClr = 1'b0;
      checkOutput("sync.snapValid", 64'(aSnapValid), 64'd1);
      checkA("sync", 0, 0, 0, -1);

      for (int v = 0; v < 13; v++) begin
         sendFrameA(vecs[v].dataLen, vecs[v].sfd, vecs[v].errIdx,
                    vecs[v].preLen, 12, 11, 1'b1);
         checkOutput($sformatf("vec%0d.snapValid", v), 64'(aSnapValid), 64'd1);
         checkA($sformatf("vec%0d", v), vecs[v].expPkts, vecs[v].expOctets,
                vecs[v].expErr, 12);
         for (int b = 0; b < 8; b++)
            checkOutput($sformatf("vec%0d.hist%0d", v, b),
                        64'(aHist[16*b +: 16]), (b == vecs[v].expBin) ? 64'd1 : 64'd0);
      end

      // Ten 72-octet frames with 12-octet gaps.
      for (int f = 0; f < 10; f++) sendFrameA(64, 8'hD5, -1, 8, 12, (f == 9) ? 11 : -1, 1'b1);
      checkA("ten64", 10, 640, 0, 120);
      checkOutput("ten64.hist1", 64'(aHist[16 +: 16]), 64'd10);
      checkOutput("ten64.hist2", 64'(aHist[32 +: 16]), 64'd0);

      // One errored-data frame and one bad-SFD frame together.
      sendFrameA(64, 8'hD5, 20, 8, 12, -1, 1'b0);
      sendFrameA(64, 8'hD4, -1, 8, 12, 11, 1'b1);
      checkA("twoErr", 0, 0, 2, 24);

      // Clearing snapshot in the frame-end cycle, then one more frame.
      sendFrameA(64, 8'hD5, -1, 8, 12, -1, 1'b0);
      sendFrameA(64, 8'hD5, -1, 8, 12, 0, 1'b1);
      checkA("snapAtEnd", 2, 128, 0, 13);
      sendFrameA(64, 8'hD5, -1, 8, 12, 11, 1'b1);
      checkA("snapAfter", 1, 64, 0, 23);

      // Reset in the middle of data; the tail must not count.
      for (int p = 0; p < 8; p++) applyStimulus((p == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checkA("midReset", 0, 0, 0, 0);
      checkOutput("midReset.hist1", 64'(aHist[16 +: 16]), 64'd0);
      checkOutput("midReset.snapValid", 64'(aSnapValid), 64'd0);
      applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 12; g++) applyStimulus(8'h00, 1'b0, 1'b0, (g == 11), (g == 11));
      aSnap = 1'b0; aClr = 1'b0;
      checkA("tail", 0, 0, 0, -1);
      sendFrameA(64, 8'hD5, -1, 8, 12, 11, 1'b1);
      checkA("afterReset", 1, 64, 0, 12);
      checkOutput("afterReset.hist1", 64'(aHist[16 +: 16]), 64'd1);

      // Idle octets saturate on 16-bit counters and stay there.
      for (int c = 0; c < 70000; c++) applyStimulus(8'h00, 1'b0, 1'b0, (c == 69999), 1'b0);
      aSnap = 1'b0;
      checkOutput("idleSat.idle", 64'(aIdle), 64'd65535);
      checkOutput("idleSat.pkts", 64'(aPkts), 64'd0);
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idleSat.snapValidLow", 64'(aSnapValid), 64'd0);
      checkOutput("idleSat.holdIdle", 64'(aIdle), 64'd65535);
      for (int c = 0; c < 10; c++) applyStimulus(8'h00, 1'b0, 1'b0, (c == 9), 1'b0);
      aSnap = 1'b0;
      checkOutput("idleSat.again", 64'(aIdle), 64'd65535);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
